// File: rtl/power_stim_pkg.sv
// rtl/power_stim_pkg.sv - shared types, ui_in field map and LFSR step for the power stimulus tile
package power_stim_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int UI_MODE_LSB    = 0;
  localparam int UI_DIV_LSB     = 2;
  localparam int UI_START_BIT   = 5;
  localparam int UI_ONESHOT_BIT = 6;

  // Galois right-shift step; a nonzero state never maps to zero
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/power_stim_sync.sv
// rtl/power_stim_sync.sv - multi-bit input synchroniser of parameterised depth
module power_stim_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // each stage takes the previous one; stage 0 takes the raw input
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  // synchroniser chain, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tt_um_power_stim.sv
// rtl/tt_um_power_stim.sv - power-test stimulus generator top; POWER_STIM_LOOPBACK_EN adds pad readback error flag
module tt_um_power_stim
  import power_stim_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          BURST_LEN   = 256,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] BURST = 16'(BURST_LEN);

  logic [7:0] ui_s;

  power_stim_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in),
    .q     (ui_s)
  );

  logic       start, oneshot;
  logic [2:0] ui_div;
  mode_e      ui_mode;

  assign start   = ui_s[UI_START_BIT];
  assign oneshot = ui_s[UI_ONESHOT_BIT];
  assign ui_div  = ui_s[UI_DIV_LSB +: 3];
  assign ui_mode = mode_e'(ui_s[UI_MODE_LSB +: 2]);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [2:0]  div_q, div_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  oe_q, oe_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        tog_q, tog_d;
  logic [15:0] step_q, step_d;
  logic        done_q, done_d;
  logic [7:0]  out_a_q, out_a_d;
  logic [7:0]  out_b_q, out_b_d;

  logic [7:0] div_limit;
  logic       tick, burst_done, ramp_entry;

  assign div_limit  = (8'd1 << div_q) - 8'd1;
  assign tick       = (state_q != ST_IDLE) && (div_cnt_q == div_limit);
  assign burst_done = oneshot && (step_q == BURST);
  assign ramp_entry = (state_q == ST_IDLE) && start && !done_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state; START low always wins over a coincident tick
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        ST_IDLE:  if (ramp_entry) state_d = ST_RAMP;
        ST_RAMP:  if (!start) state_d = ST_DRAIN;
                  else if (tick && oe_q == 8'hFF) state_d = ST_RUN;
        ST_RUN:   if (!start || burst_done) state_d = ST_DRAIN;
        ST_DRAIN: if (oe_q == 8'h00) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // divider, enable ramp, pattern generation and one-shot bookkeeping
  always_comb begin
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    oe_d      = oe_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    tog_d     = tog_q;
    step_d    = step_q;
    done_d    = done_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    if (ena) begin
      if (state_q == ST_IDLE || tick) begin
        div_cnt_d = 8'd0;
        div_d     = ui_div;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
      case (state_q)
        ST_IDLE: begin
          oe_d    = 8'h00;
          out_a_d = 8'h00;
          out_b_d = 8'h00;
          if (!start) done_d = 1'b0;
          if (ramp_entry) begin
            oe_d   = 8'h01;
            mode_d = ui_mode;
            cnt_d  = 8'd0;
            lfsr_d = LFSR_SEED;
            tog_d  = 1'b0;
            step_d = 16'd0;
          end
        end
        ST_RAMP: if (start && tick && oe_q != 8'hFF) oe_d = {oe_q[6:0], 1'b1};
        ST_RUN: begin
          if (start && burst_done) begin
            done_d = 1'b1;
          end else if (start && tick) begin
            if (step_q != BURST) step_d = step_q + 16'd1;
            case (mode_q)
              MODE_COUNT: begin
                cnt_d   = cnt_q + 8'd1;
                out_a_d = cnt_d;
                out_b_d = ~cnt_d;
              end
              MODE_LFSR: begin
                lfsr_d  = lfsr_next(lfsr_q);
                out_a_d = lfsr_d[7:0];
                out_b_d = lfsr_d[15:8];
              end
              MODE_TOGGLE: begin
                tog_d   = ~tog_q;
                out_a_d = {8{tog_d}};
                out_b_d = {8{tog_d}};
              end
              default: begin
                out_a_d = 8'h00;
                out_b_d = 8'h00;
              end
            endcase
          end
        end
        ST_DRAIN: begin
          if (oe_q == 8'h00) begin
            out_a_d = 8'h00;
            out_b_d = 8'h00;
          end else if (tick) begin
            oe_d = {1'b0, oe_q[7:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // datapath registers; reset drops every enable immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 3'd0;
      div_cnt_q <= 8'd0;
      oe_q      <= 8'h00;
      mode_q    <= MODE_STATIC;
      cnt_q     <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      tog_q     <= 1'b0;
      step_q    <= 16'd0;
      done_q    <= 1'b0;
      out_a_q   <= 8'h00;
      out_b_q   <= 8'h00;
    end else begin
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      oe_q      <= oe_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      tog_q     <= tog_d;
      step_q    <= step_d;
      done_q    <= done_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
    end
  end

  assign uio_out = out_b_q;
  assign uio_oe  = oe_q;

  logic unused_bits;

`ifdef POWER_STIM_LOOPBACK_EN
  logic [7:0] pad_q, prev_b_q, prev_oe_q;
  logic       err_q, err_d;

  // pad sample and the value/enables driven when it was sampled, kept aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_q     <= 8'h00;
      prev_b_q  <= 8'h00;
      prev_oe_q <= 8'h00;
    end else begin
      pad_q     <= uio_in;
      prev_b_q  <= out_b_q;
      prev_oe_q <= oe_q;
    end
  end

  // sticky readback error while running, cleared on ramp entry
  always_comb begin
    err_d = err_q;
    if (ena) begin
      if (ramp_entry) err_d = 1'b0;
      else if (state_q == ST_RUN && |((pad_q ^ prev_b_q) & prev_oe_q)) err_d = 1'b1;
    end
  end

  // error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign uo_out      = {err_q, out_a_q[6:0]};
  assign unused_bits = &{1'b0, ui_s[7], out_a_q[7]};
`else
  assign uo_out      = out_a_q;
  assign unused_bits = &{1'b0, ui_s[7], uio_in};
`endif

endmodule
